data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_pkg.sv | 30 +++
 rtl/data_mem_responder_dmem_array.sv | 32 +++
 rtl/data_mem_responder.sv | 158 +++++++++++++++
 tb/tb_data_mem_responder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : data_mem_responder_pkg                                      |
// | Description : Shared types and defaults for the data memory responder.    |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
`default_nettype none

package data_mem_responder_pkg;

    localparam int c_WAIT_CYCLES_DEFAULT = 2;
    localparam int c_DEPTH_WORDS_DEFAULT = 128;
    localparam int c_CNT_WIDTH           = 16;
    localparam int c_WCNT_WIDTH          = 4;
    localparam int c_ADDR_WIDTH          = 9;
    localparam int c_DATA_WIDTH          = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Word accesses only: any nonzero byte offset is an error.
    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return byte_off != 2'b00;
    endfunction

endpackage

`default_nettype wire

// File: rtl/data_mem_responder_dmem_array.sv
// +----------------------------------------------------------------------------+
// | Module      : dmem_array                                                  |
// | Description : Word storage, one synchronous write port, async read port.  |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
`default_nettype none

module dmem_array #(
    parameter int DEPTH_WORDS = 128,
    parameter int IDX_W       = 7
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_addr,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata
);

    // Contents deliberately have no reset.
    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// +----------------------------------------------------------------------------+
// | Module      : data_mem_responder                                          |
// | Description : Single-outstanding data memory slave with wait states.      |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
`default_nettype none

module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int WAIT_CYCLES = c_WAIT_CYCLES_DEFAULT,
    parameter int DEPTH_WORDS = c_DEPTH_WORDS_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [c_ADDR_WIDTH-1:0] req_addr,
    input  logic [c_DATA_WIDTH-1:0] req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [c_DATA_WIDTH-1:0] rsp_rdata,
    output logic                    rsp_err,
    output logic [c_CNT_WIDTH-1:0]  access_cnt
);

    localparam int c_IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [c_WCNT_WIDTH-1:0] c_WAIT_LOAD =
        c_WCNT_WIDTH'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_WCNT_WIDTH-1:0] r_wait_cnt;
    logic [c_WCNT_WIDTH-1:0] w_wait_cnt_nxt;
    logic                    w_accept;
    logic                    w_enter_resp;
    logic                    w_rsp_done;

    logic                    r_we;
    logic [c_ADDR_WIDTH-1:0] r_addr;
    logic [c_DATA_WIDTH-1:0] r_wdata;
    logic [c_DATA_WIDTH-1:0] r_rsp_rdata;
    logic                    r_rsp_err;
    logic [c_CNT_WIDTH-1:0]  r_access_cnt;

    logic                    w_cur_we;
    logic [c_ADDR_WIDTH-1:0] w_cur_addr;
    logic [c_DATA_WIDTH-1:0] w_cur_wdata;
    logic                    w_misaligned;
    logic [c_IDX_W-1:0]      w_idx;
    logic                    w_mem_we;
    logic [c_DATA_WIDTH-1:0] w_mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_accept       = 1'b0;
        w_enter_resp   = 1'b0;
        w_rsp_done     = 1'b0;
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        w_state_nxt  = RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_nxt    = WAIT;
                        w_wait_cnt_nxt = c_WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_state_nxt  = RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt - 1'b1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_rsp_done  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // With zero wait states the access happens on the acceptance edge itself,
    // so the live request fields are used instead of the captured copies.
    assign w_cur_we     = (r_state == IDLE) ? req_we    : r_we;
    assign w_cur_addr   = (r_state == IDLE) ? req_addr  : r_addr;
    assign w_cur_wdata  = (r_state == IDLE) ? req_wdata : r_wdata;
    assign w_misaligned = is_misaligned(w_cur_addr[1:0]);
    assign w_idx        = c_IDX_W'(32'(w_cur_addr[c_ADDR_WIDTH-1:2]) % DEPTH_WORDS);
    assign w_mem_we     = w_enter_resp && w_cur_we && !w_misaligned;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (c_IDX_W)
    ) u_dmem_array (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_addr  (w_idx),
        .i_wdata (w_cur_wdata),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rsp_rdata  <= '0;
            r_rsp_err    <= 1'b0;
            r_access_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (w_enter_resp) begin
                r_rsp_err   <= w_misaligned;
                r_rsp_rdata <= (w_misaligned || w_cur_we) ? '0 : w_mem_rdata;
            end
            if (w_rsp_done && (r_access_cnt != '1)) begin
                r_access_cnt <= r_access_cnt + 1'b1;
            end
        end
    end

    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_err    = r_rsp_err;
    assign access_cnt = r_access_cnt;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_data_mem_responder                                       |
// | Description : Randomized self-checking bench, three parameter variants.   |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_data_mem_responder;

    localparam int c_N      = 3;
    localparam int c_WC [3] = '{2, 0, 3};
    localparam int c_DW [3] = '{128, 128, 64};

    logic        clk;
    logic        rst;
    logic        r_req_valid [c_N];
    logic        r_req_we    [c_N];
    logic [8:0]  r_req_addr  [c_N];
    logic [31:0] r_req_wdata [c_N];
    logic        r_rsp_ready [c_N];
    logic        w_req_ready [c_N];
    logic        w_rsp_valid [c_N];
    logic [31:0] w_rsp_rdata [c_N];
    logic        w_rsp_err   [c_N];
    logic [15:0] w_access_cnt[c_N];

    int          r_checks;
    int          r_errors;
    logic [31:0] r_mod_mem   [c_N][128];
    bit          r_mod_known [c_N][128];
    logic [15:0] r_exp_cnt   [c_N];

    for (genvar gi = 0; gi < c_N; gi++) begin : g_dut
        data_mem_responder #(
            .WAIT_CYCLES (c_WC[gi]),
            .DEPTH_WORDS (c_DW[gi])
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (r_req_valid[gi]),
            .req_ready  (w_req_ready[gi]),
            .req_we     (r_req_we[gi]),
            .req_addr   (r_req_addr[gi]),
            .req_wdata  (r_req_wdata[gi]),
            .rsp_valid  (w_rsp_valid[gi]),
            .rsp_ready  (r_rsp_ready[gi]),
            .rsp_rdata  (w_rsp_rdata[gi]),
            .rsp_err    (w_rsp_err[gi]),
            .access_cnt (w_access_cnt[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        r_checks++;
        if (obs !== exp) begin
            r_errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full request/response exchange on instance k; starts and ends away
    // from the clock edge with the instance idle.
    task automatic do_txn(input int k, input logic we, input logic [8:0] addr,
                          input logic [31:0] wdata, input int bp);
        int          lat;
        int          idx;
        bit          mis;
        bit          check_d;
        logic [31:0] exp_d;

        idx     = int'(addr >> 2) % c_DW[k];
        mis     = (addr[1:0] != 2'b00);
        exp_d   = 32'h0;
        check_d = 1'b1;
        if (!mis && !we) begin
            check_d = r_mod_known[k][idx];
            exp_d   = r_mod_mem[k][idx];
        end

        chk("req_ready_idle", 32'(w_req_ready[k]), 32'h1);
        r_req_valid[k] = 1'b1;
        r_req_we[k]    = we;
        r_req_addr[k]  = addr;
        r_req_wdata[k] = wdata;
        @(posedge clk);
        #1;
        // Garbage requests while busy must be ignored.
        r_req_valid[k] = 1'($urandom_range(0, 1));
        r_req_we[k]    = 1'($urandom_range(0, 1));
        r_req_addr[k]  = 9'($urandom);
        r_req_wdata[k] = $urandom;

        lat = 0;
        while (w_rsp_valid[k] !== 1'b1 && lat < 40) begin
            chk("req_ready_wait", 32'(w_req_ready[k]), 32'h0);
            r_rsp_ready[k] = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            lat++;
        end
        r_rsp_ready[k] = 1'b0;
        chk("latency", 32'(lat), 32'(c_WC[k]));

        for (int i = 0; i <= bp; i++) begin
            chk("rsp_valid", 32'(w_rsp_valid[k]), 32'h1);
            chk("req_ready_resp", 32'(w_req_ready[k]), 32'h0);
            chk("rsp_err", 32'(w_rsp_err[k]), 32'(mis));
            if (check_d) chk("rsp_rdata", w_rsp_rdata[k], exp_d);
            chk("cnt_hold", 32'(w_access_cnt[k]), 32'(r_exp_cnt[k]));
            if (i < bp) begin
                @(posedge clk);
                #1;
            end
        end

        r_rsp_ready[k] = 1'b1;
        @(posedge clk);
        #1;
        r_rsp_ready[k] = 1'b0;
        r_req_valid[k] = 1'b0;
        if (r_exp_cnt[k] != 16'hFFFF) r_exp_cnt[k]++;
        if (we && !mis) begin
            r_mod_mem[k][idx]   = wdata;
            r_mod_known[k][idx] = 1'b1;
        end
        chk("rsp_valid_done", 32'(w_rsp_valid[k]), 32'h0);
        chk("req_ready_done", 32'(w_req_ready[k]), 32'h1);
        chk("access_cnt", 32'(w_access_cnt[k]), 32'(r_exp_cnt[k]));
    endtask

    task automatic chk_reset_outputs(input int k);
        chk("rst_req_ready", 32'(w_req_ready[k]), 32'h1);
        chk("rst_rsp_valid", 32'(w_rsp_valid[k]), 32'h0);
        chk("rst_rsp_rdata", w_rsp_rdata[k], 32'h0);
        chk("rst_rsp_err", 32'(w_rsp_err[k]), 32'h0);
        chk("rst_access_cnt", 32'(w_access_cnt[k]), 32'h0);
    endtask

    initial begin
        logic [8:0] addr;
        int         word;
        int         low;

        r_checks = 0;
        r_errors = 0;
        rst      = 1'b1;
        for (int k = 0; k < c_N; k++) begin
            r_req_valid[k] = 1'b0;
            r_req_we[k]    = 1'b0;
            r_req_addr[k]  = '0;
            r_req_wdata[k] = '0;
            r_rsp_ready[k] = 1'b0;
            r_exp_cnt[k]   = '0;
            for (int w = 0; w < 128; w++) begin
                r_mod_known[k][w] = 1'b0;
                r_mod_mem[k][w]   = '0;
            end
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < c_N; k++) chk_reset_outputs(k);
        rst = 1'b0;
        @(negedge clk);

        // Store then load, backpressure, misaligned store.
        do_txn(0, 1'b1, 9'h010, 32'h12345678, 0);
        do_txn(0, 1'b0, 9'h010, 32'h0, 0);
        do_txn(0, 1'b0, 9'h010, 32'h0, 5);
        do_txn(0, 1'b1, 9'h013, 32'hDEADBEEF, 1);
        do_txn(0, 1'b0, 9'h010, 32'h0, 0);

        // Zero-wait variant.
        do_txn(1, 1'b1, 9'h044, 32'hCAFEF00D, 0);
        do_txn(1, 1'b0, 9'h044, 32'h0, 2);
        do_txn(1, 1'b0, 9'h046, 32'h0, 0);

        // Address wrap on the 64-word variant: 0x1FC aliases word 63.
        do_txn(2, 1'b1, 9'h1FC, 32'h0BADCAFE, 0);
        do_txn(2, 1'b0, 9'h0FC, 32'h0, 0);

        // Randomized traffic on every variant.
        for (int k = 0; k < c_N; k++) begin
            for (int n = 0; n < 40; n++) begin
                word = $urandom_range(0, 15) + 64 * $urandom_range(0, 1);
                low  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
                addr = {7'(word), 2'(low)};
                do_txn(k, 1'($urandom_range(0, 1)), addr, $urandom, $urandom_range(0, 3));
            end
        end

        // Reset in the middle of a wait: the pending store must be dropped.
        do_txn(0, 1'b1, 9'h020, 32'h0, 0);
        r_req_valid[0] = 1'b1;
        r_req_we[0]    = 1'b1;
        r_req_addr[0]  = 9'h020;
        r_req_wdata[0] = 32'hAAAA5555;
        @(posedge clk);
        #1;
        r_req_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_reset_outputs(0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < c_N; k++) r_exp_cnt[k] = '0;
        @(negedge clk);
        do_txn(0, 1'b0, 9'h020, 32'h0, 0);

        // Counter saturation from a preloaded value.
        force g_dut[2].u_dut.r_access_cnt = 16'hFFFE;
        #1;
        release g_dut[2].u_dut.r_access_cnt;
        r_exp_cnt[2] = 16'hFFFE;
        chk("cnt_preload", 32'(w_access_cnt[2]), 32'h0000FFFE);
        do_txn(2, 1'b1, 9'h008, 32'h11112222, 0);
        do_txn(2, 1'b0, 9'h008, 32'h0, 1);
        do_txn(2, 1'b1, 9'h00B, 32'h33334444, 0);
        chk("cnt_saturated", 32'(w_access_cnt[2]), 32'h0000FFFF);

        $display("CHECKS %0d ERRORS %0d", r_checks, r_errors);
        $finish;
    end

endmodule

`default_nettype wire
